// File: rtl/db_pkg.sv
// Shared constants and width helper for the push-button / switch debouncer bank.
package db_pkg;

    // Board clock and the prescaler value that gives a 1 kHz sample tick from it.
    localparam int CLK_HZ_TN9K  = 27_000_000;
    localparam int DB_TICK_1KHZ = CLK_HZ_TN9K / 1000;

    // Bits needed for a counter that must be able to hold max_val.
    // Always at least one bit wide so degenerate parameters still elaborate.
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/db_channel.sv
// One debouncer channel: polarity normalise, two-flop synchroniser, tick-sampled
// stability counter, rise/fall pulses, long-press hold counter and sticky event.
module db_channel
    import db_pkg::*;
#(
    parameter int STABLE_SAMPLES = 10,
    parameter int HOLD_SAMPLES   = 1000,
    parameter bit ACTIVE_LOW     = 1'b0
) (
    input  logic i_clk,
    input  logic reset,
    input  logic tick,
    input  logic i_db,
    input  logic i_ack,
    output logic o_db,
    output logic o_rise,
    output logic o_fall,
    output logic o_hold,
    output logic o_event
);

    localparam int CW = cnt_width(STABLE_SAMPLES);
    localparam int HW = cnt_width(HOLD_SAMPLES);

    // cnt+1 == STABLE_SAMPLES is the same as cnt == STABLE_SAMPLES-1, which
    // avoids a carry into an extra bit when comparing.
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_SAMPLES - 1);
    localparam logic [HW-1:0] HOLD_MAX    = HW'(HOLD_SAMPLES);

    logic          norm;
    logic          sync_meta;
    logic          sync_q;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hcnt;
    logic          change;

    assign norm = i_db ^ ACTIVE_LOW;

    // The debounced level flips on this edge: a tick, still disagreeing, and
    // this is the last disagreeing sample the counter was waiting for.
    assign change = tick && (sync_q != o_db) && (cnt == STABLE_LAST);

    // Two-flop synchroniser on the polarity-normalised input.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sync_meta <= norm;
            sync_q    <= sync_meta;
        end
    end

    // Stability counter and debounced level; pulses are registered alongside
    // the level so they line up with the first cycle showing the new value.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            cnt    <= '0;
            o_db   <= 1'b0;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
        end else begin
            o_rise <= change && !o_db;
            o_fall <= change && o_db;
            if (tick) begin
                if (sync_q == o_db) begin
                    cnt <= '0;
                end else if (change) begin
                    o_db <= sync_q;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Long-press counter: counts ticks while pressed, saturates, and clears on
    // the falling edge itself so o_hold drops together with o_db.
    always_ff @(posedge i_clk) begin
        if (reset || !o_db || change) begin
            hcnt <= '0;
        end else if (tick && (hcnt != HOLD_MAX)) begin
            hcnt <= hcnt + 1'b1;
        end
    end

    assign o_hold = (hcnt == HOLD_MAX);

    // Sticky press flag; a new press wins over an acknowledge in the same cycle.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            o_event <= 1'b0;
        end else if (o_rise) begin
            o_event <= 1'b1;
        end else if (i_ack) begin
            o_event <= 1'b0;
        end
    end

endmodule

// File: rtl/db_bank.sv
// Multi-channel debouncer bank: shared sample-tick prescaler, one db_channel per
// input, and the interrupt reduction over the sticky event flags.
module db_bank
    import db_pkg::*;
#(
    parameter int                  CHANNELS       = 4,
    parameter int                  TICK_DIV       = DB_TICK_1KHZ,
    parameter int                  STABLE_SAMPLES = 10,
    parameter int                  HOLD_SAMPLES   = 1000,
    parameter logic [CHANNELS-1:0] ACTIVE_LOW     = {CHANNELS{1'b0}}
) (
    input  logic                i_clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] i_db,
    input  logic [CHANNELS-1:0] i_ack,
    output logic [CHANNELS-1:0] o_db,
    output logic [CHANNELS-1:0] o_rise,
    output logic [CHANNELS-1:0] o_fall,
    output logic [CHANNELS-1:0] o_hold,
    output logic [CHANNELS-1:0] o_event,
    output logic                o_irq
);

    localparam int             PW       = cnt_width(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_cnt;
    logic          tick;

    assign tick = (pre_cnt == PRE_LAST);

    // Free-running prescaler 0..TICK_DIV-1; tick marks its last count.
    always_ff @(posedge i_clk) begin
        if (reset || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        db_channel #(
            .STABLE_SAMPLES (STABLE_SAMPLES),
            .HOLD_SAMPLES   (HOLD_SAMPLES),
            .ACTIVE_LOW     (ACTIVE_LOW[g])
        ) u_ch (
            .i_clk   (i_clk),
            .reset   (reset),
            .tick    (tick),
            .i_db    (i_db[g]),
            .i_ack   (i_ack[g]),
            .o_db    (o_db[g]),
            .o_rise  (o_rise[g]),
            .o_fall  (o_fall[g]),
            .o_hold  (o_hold[g]),
            .o_event (o_event[g])
        );
    end

    assign o_irq = |o_event;

endmodule

// File: tb/tb_db_bank.sv
// Self-checking bench for db_bank: directed scenarios plus randomized input,
// acknowledge and reset activity, all compared against a behavioural model.
module tb_db_bank;

    localparam int             CH = 2;
    localparam int             TD = 4;
    localparam int             SS = 3;
    localparam int             HS = 5;
    localparam logic [CH-1:0] AL = 2'b10;

    logic          i_clk = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] i_db  = '0;
    logic [CH-1:0] i_ack = '0;
    logic [CH-1:0] o_db, o_rise, o_fall, o_hold, o_event;
    logic          o_irq;

    int checks   = 0;
    int failures = 0;

    db_bank #(
        .CHANNELS       (CH),
        .TICK_DIV       (TD),
        .STABLE_SAMPLES (SS),
        .HOLD_SAMPLES   (HS),
        .ACTIVE_LOW     (AL)
    ) dut (
        .i_clk   (i_clk),
        .reset   (reset),
        .i_db    (i_db),
        .i_ack   (i_ack),
        .o_db    (o_db),
        .o_rise  (o_rise),
        .o_fall  (o_fall),
        .o_hold  (o_hold),
        .o_event (o_event),
        .o_irq   (o_irq)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural model: edge index since reset, history of normalised inputs,
    // run length of disagreeing samples and ticks held since each press.
    int            m_k;
    bit [CH-1:0]   m_hist[$];
    bit [CH-1:0]   m_db, m_rise, m_fall, m_event;
    int            m_run[CH];
    int            m_ht[CH];

    task automatic model_edge();
        bit [CH-1:0] smp;
        bit [CH-1:0] nrise;
        bit [CH-1:0] nfall;
        bit [CH-1:0] nev;
        bit          tk;
        if (reset) begin
            m_k = 0;
            m_hist.delete();
            m_db = '0; m_rise = '0; m_fall = '0; m_event = '0;
            for (int c = 0; c < CH; c++) begin
                m_run[c] = 0;
                m_ht[c]  = 0;
            end
            return;
        end
        tk  = ((m_k + 1) % TD) == 0;
        smp = (m_hist.size() >= 2) ? m_hist[m_hist.size() - 2] : '0;
        m_hist.push_back(i_db ^ AL);
        if (m_hist.size() > 2) void'(m_hist.pop_front());
        nev   = m_rise | (m_event & ~i_ack);
        nrise = '0;
        nfall = '0;
        for (int c = 0; c < CH; c++) begin
            if (tk) begin
                if (smp[c] == m_db[c]) begin
                    m_run[c] = 0;
                end else begin
                    m_run[c]++;
                    if (m_run[c] == SS) begin
                        m_run[c] = 0;
                        m_db[c]  = ~m_db[c];
                        if (m_db[c]) nrise[c] = 1'b1;
                        else         nfall[c] = 1'b1;
                    end
                end
                if (m_db[c] && !nrise[c] && m_ht[c] < HS) m_ht[c]++;
            end
            if (!m_db[c] || nrise[c]) m_ht[c] = 0;
        end
        m_rise  = nrise;
        m_fall  = nfall;
        m_event = nev;
        m_k++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit [CH-1:0] exp_hold;
        @(posedge i_clk);
        model_edge();
        #1;
        for (int c = 0; c < CH; c++) exp_hold[c] = m_db[c] && (m_ht[c] == HS);
        chk("model_db",    32'(o_db),    32'(m_db));
        chk("model_rise",  32'(o_rise),  32'(m_rise));
        chk("model_fall",  32'(o_fall),  32'(m_fall));
        chk("model_hold",  32'(o_hold),  32'(exp_hold));
        chk("model_event", 32'(o_event), 32'(m_event));
        chk("model_irq",   32'(o_irq),   32'(|m_event));
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int cyc;
        bit seen;
        bit prev_hold;

        // Reset with ch0 pressed (and ch1 pressed, being active-low and driven 0).
        reset = 1'b1;
        i_db  = 2'b01;
        i_ack = '0;
        repeat (10) step();
        chk("rst_db",    32'(o_db),    0);
        chk("rst_rise",  32'(o_rise),  0);
        chk("rst_fall",  32'(o_fall),  0);
        chk("rst_hold",  32'(o_hold),  0);
        chk("rst_event", 32'(o_event), 0);
        chk("rst_irq",   32'(o_irq),   0);

        reset = 1'b0;
        lat = 0;
        while (!o_db[0] && lat < 40) begin
            step();
            lat++;
        end
        chk("rst_latency_in_window",
            32'((lat >= 2 + (SS - 1) * TD + 1) && (lat <= 2 + SS * TD)), 1);

        // Clear the events raised by the post-reset presses.
        step();
        i_ack = 2'b11;
        step();
        i_ack = '0;
        chk("ack_all_event", 32'(o_event), 0);
        chk("ack_all_irq",   32'(o_irq),   0);

        // Clean press on ch0 from a settled released state, with ack in the rise cycle.
        i_db[0] = 1'b0;
        cyc = 0;
        while (o_db[0] && cyc < 40) begin
            step();
            cyc++;
        end
        chk("release_db0", 32'(o_db[0]), 0);
        repeat (8) step();
        i_db[0] = 1'b1;
        cyc = 0;
        while (!o_rise[0] && cyc < 40) begin
            step();
            cyc++;
        end
        chk("press_rise",    32'(o_rise[0]), 1);
        chk("press_db",      32'(o_db[0]),   1);
        chk("press_ch1_db",  32'(o_db[1]),   1);
        i_ack[0] = 1'b1;
        step();
        i_ack[0] = 1'b0;
        chk("rise_one_cycle",    32'(o_rise[0]), 0);
        chk("ack_collide_event", 32'(o_event[0]), 1);
        chk("press_irq",         32'(o_irq), 1);
        chk("press_ch1_quiet",   32'({o_rise[1], o_fall[1]}), 0);

        // Long press: hold must appear exactly HS ticks after the rise.
        cyc = 1;
        while (!o_hold[0] && cyc < 100) begin
            step();
            cyc++;
        end
        chk("hold_delay_cycles", 32'(cyc), 32'(HS * TD));

        // Plain acknowledge clears the event one cycle later.
        i_ack[0] = 1'b1;
        step();
        i_ack[0] = 1'b0;
        chk("ack_clear_event", 32'(o_event[0]), 0);
        chk("ack_clear_irq",   32'(o_irq), 0);

        // Release: fall pulse and hold drop in the same cycle.
        i_db[0]   = 1'b0;
        prev_hold = o_hold[0];
        cyc = 0;
        while (!o_fall[0] && cyc < 40) begin
            prev_hold = o_hold[0];
            step();
            cyc++;
        end
        chk("fall_pulse",       32'(o_fall[0]), 1);
        chk("fall_hold_drop",   32'(o_hold[0]), 0);
        chk("hold_before_fall", 32'(prev_hold), 1);
        step();
        chk("fall_one_cycle", 32'(o_fall[0]), 0);

        // Bounce: toggle every 2 ticks for 20 ticks, never enough to pass.
        repeat (8) step();
        seen = 1'b0;
        for (int t = 0; t < 10; t++) begin
            i_db[0] = ~i_db[0];
            for (int j = 0; j < 2 * TD; j++) begin
                step();
                seen |= o_db[0] | o_rise[0] | o_fall[0];
            end
        end
        i_db[0] = 1'b0;
        chk("bounce_quiet", 32'(seen), 0);

        // Polarity: ch1 is active-low.
        i_db[1] = 1'b1;
        cyc = 0;
        while (o_db[1] && cyc < 40) begin
            step();
            cyc++;
        end
        chk("pol_release", 32'(o_db[1]), 0);
        repeat (4) step();
        i_db[1] = 1'b0;
        cyc = 0;
        while (!o_rise[1] && cyc < 40) begin
            step();
            cyc++;
        end
        chk("pol_rise", 32'(o_rise[1]), 1);
        chk("pol_db",   32'(o_db[1]),   1);

        // Reset mid-count, input released afterwards: no rise may follow.
        repeat (8) step();
        i_db[0] = 1'b1;
        repeat (7) step();
        reset = 1'b1;
        repeat (3) step();
        chk("rst_mid_db", 32'(o_db), 0);
        reset   = 1'b0;
        i_db[0] = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            step();
            seen |= o_rise[0];
        end
        chk("rst_mid_no_rise", 32'(seen), 0);

        // Reset mid-count with input still held: rise comes only after a full window.
        i_db[0] = 1'b1;
        repeat (7) step();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        lat = 0;
        while (!o_rise[0] && lat < 40) begin
            step();
            lat++;
        end
        chk("rst_held_latency",
            32'((lat >= 2 + (SS - 1) * TD + 1) && (lat <= 2 + SS * TD)), 1);

        // Randomized segments of input levels, acks and occasional resets.
        for (int seg = 0; seg < 150; seg++) begin
            i_db  = 2'($urandom);
            i_ack = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            reset = ($urandom_range(0, 40) == 0);
            repeat ($urandom_range(1, 40)) step();
        end
        reset = 1'b0;
        i_ack = '0;
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
